// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, IF/ID pipeline register and ID-stage redirect
// resolution (beq/bne/j/jal/jr), with a jr misalignment flag and a saturating redirect counter.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_F,
    input  logic [2:0]  br_op,
    input  logic        equal,
    input  logic [31:0] ra_data,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        align_err,
    output logic [15:0] taken_cnt
);

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_J    = 3'b011;
    localparam logic [2:0] BR_JAL  = 3'b100;
    localparam logic [2:0] BR_JR   = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcid_q,  pcid_d;
    logic        align_q, align_d;
    logic [15:0] cnt_q,   cnt_d;

    logic [31:0] pc_seq;
    logic [31:0] pcid_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        redirect;
    logic [31:0] redirect_target;

    // Targets are derived from the instruction currently in ID, not the one being fetched.
    assign pc_seq     = pc_q + 32'd4;
    assign pcid_plus4 = pcid_q + 32'd4;
    assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_target  = pcid_plus4 + br_offset;
    assign j_target   = {pcid_plus4[31:28], instr_q[25:0], 2'b00};
    assign jr_target  = {ra_data[31:2], 2'b00};

    always_comb begin
        redirect        = 1'b0;
        redirect_target = pc_seq;
        case (br_op)
            BR_BEQ: begin
                redirect        = equal;
                redirect_target = br_target;
            end
            BR_BNE: begin
                redirect        = ~equal;
                redirect_target = br_target;
            end
            BR_J, BR_JAL: begin
                redirect        = 1'b1;
                redirect_target = j_target;
            end
            BR_JR: begin
                redirect        = 1'b1;
                redirect_target = jr_target;
            end
            BR_NONE: begin
                redirect        = 1'b0;
                redirect_target = pc_seq;
            end
            default: begin
                redirect        = 1'b0;
                redirect_target = pc_seq;
            end
        endcase
    end

    // A stalled edge holds all pipeline state; the misalignment flag only fires on a real jr commit.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcid_d  = pcid_q;
        cnt_d   = cnt_q;
        align_d = 1'b0;
        if (!stall) begin
            pc_d    = redirect ? redirect_target : pc_seq;
            instr_d = instr_F;
            pcid_d  = pc_q;
            align_d = (br_op == BR_JR) && (ra_data[1:0] != 2'b00);
            if (redirect && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcid_q  <= RESET_PC;
            align_q <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcid_q  <= pcid_d;
            align_q <= align_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_F      = pc_q;
    assign instr_D   = instr_q;
    assign pc_D      = pcid_q;
    assign pc8_D     = pcid_q + 32'd8;
    assign align_err = align_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: inputs change and outputs are checked on the falling edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] instr_F;
    logic [2:0]  br_op;
    logic        equal;
    logic [31:0] ra_data;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        align_err;
    logic [15:0] taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    if_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .instr_F   (instr_F),
        .br_op     (br_op),
        .equal     (equal),
        .ra_data   (ra_data),
        .pc_F      (pc_F),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .align_err (align_err),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc_F"},      pc_F,      32'h0000_3000);
        chk({tag, ".pc_D"},      pc_D,      32'h0000_3000);
        chk({tag, ".instr_D"},   instr_D,   32'h0000_0000);
        chk({tag, ".pc8_D"},     pc8_D,     32'h0000_3008);
        chk({tag, ".align_err"}, {31'd0, align_err}, 32'd0);
        chk({tag, ".taken_cnt"}, {16'd0, taken_cnt}, 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        stall   = 1'b0;
        instr_F = 32'h0;
        br_op   = 3'b000;
        equal   = 1'b0;
        ra_data = 32'h0;

        // Reset holds regardless of clock activity
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");

        // Sequential fetch
        reset   = 1'b1;
        instr_F = 32'h1111_0000;
        chk("seq0.pc_F", pc_F, 32'h0000_3000);
        tick();
        chk("seq1.pc_F", pc_F, 32'h0000_3004);
        chk("seq1.pc_D", pc_D, 32'h0000_3000);
        chk("seq1.instr_D", instr_D, 32'h1111_0000);
        instr_F = 32'h1111_0004;
        tick();
        chk("seq2.pc_F", pc_F, 32'h0000_3008);
        chk("seq2.pc_D", pc_D, 32'h0000_3004);
        instr_F = 32'h1111_0008;
        tick();
        chk("seq3.pc_F", pc_F, 32'h0000_300C);
        chk("seq3.pc_D", pc_D, 32'h0000_3008);
        chk("seq3.cnt", {16'd0, taken_cnt}, 32'd0);
        instr_F = 32'h1111_000C;
        tick();
        chk("seq4.pc_F", pc_F, 32'h0000_3010);

        // beq taken, offset -4 words
        instr_F = 32'h1000_FFFC;
        tick();
        chk("beq.pc_D", pc_D, 32'h0000_3010);
        chk("beq.instr_D", instr_D, 32'h1000_FFFC);
        br_op   = 3'b001;
        equal   = 1'b1;
        instr_F = 32'hDDDD_0001;
        tick();
        chk("beqT.pc_F", pc_F, 32'h0000_3004);
        chk("beqT.slot_pc_D", pc_D, 32'h0000_3014);
        chk("beqT.slot_instr", instr_D, 32'hDDDD_0001);
        chk("beqT.cnt", {16'd0, taken_cnt}, 32'd1);

        // beq not taken
        br_op   = 3'b000;
        instr_F = 32'h1000_FFFC;
        tick();
        chk("beqN.pc_D", pc_D, 32'h0000_3004);
        br_op   = 3'b001;
        equal   = 1'b0;
        instr_F = 32'h0;
        tick();
        chk("beqN.pc_F", pc_F, 32'h0000_300C);
        chk("beqN.cnt", {16'd0, taken_cnt}, 32'd1);

        // Advance to pc_F = 3020 for jal
        br_op = 3'b000;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_jal.pc_F", pc_F, 32'h0000_3020);
        instr_F = 32'h0C00_0C10;
        tick();
        chk("jal.pc_D", pc_D, 32'h0000_3020);
        chk("jal.pc8_D", pc8_D, 32'h0000_3028);
        br_op   = 3'b100;
        instr_F = 32'h0;
        tick();
        chk("jal.pc_F", pc_F, 32'h0000_3040);
        chk("jal.cnt", {16'd0, taken_cnt}, 32'd2);

        // jr to a misaligned register value
        br_op   = 3'b101;
        ra_data = 32'h0000_3101;
        tick();
        chk("jr.pc_F", pc_F, 32'h0000_3100);
        chk("jr.align_err", {31'd0, align_err}, 32'd1);
        chk("jr.cnt", {16'd0, taken_cnt}, 32'd3);
        br_op = 3'b000;
        tick();
        chk("jr_after.align_err", {31'd0, align_err}, 32'd0);
        chk("jr_after.pc_F", pc_F, 32'h0000_3104);

        // Reserved op 110 never redirects
        br_op = 3'b110;
        equal = 1'b1;
        tick();
        chk("op110.pc_F", pc_F, 32'h0000_3108);
        chk("op110.cnt", {16'd0, taken_cnt}, 32'd3);

        // bne held in ID by stall while equal toggles
        br_op   = 3'b000;
        instr_F = 32'h1400_0004;
        tick();
        chk("bne.pc_D", pc_D, 32'h0000_3108);
        br_op   = 3'b010;
        stall   = 1'b1;
        instr_F = 32'hEEEE_0000;
        for (int i = 0; i < 3; i++) begin
            equal = i[0];
            tick();
            chk("stall.pc_F", pc_F, 32'h0000_310C);
            chk("stall.pc_D", pc_D, 32'h0000_3108);
            chk("stall.instr_D", instr_D, 32'h1400_0004);
            chk("stall.cnt", {16'd0, taken_cnt}, 32'd3);
        end
        stall = 1'b0;
        equal = 1'b1;
        tick();
        chk("release.pc_F", pc_F, 32'h0000_3110);
        chk("release.pc_D", pc_D, 32'h0000_310C);
        chk("release.instr_D", instr_D, 32'hEEEE_0000);
        chk("release.cnt", {16'd0, taken_cnt}, 32'd3);

        // Misaligned jr under stall must not flag or move
        stall   = 1'b1;
        br_op   = 3'b101;
        ra_data = 32'h0000_0001;
        tick();
        chk("stall_jr.align_err", {31'd0, align_err}, 32'd0);
        chk("stall_jr.pc_F", pc_F, 32'h0000_3110);
        stall = 1'b0;

        // Jump to the top of the address space and wrap
        ra_data = 32'hFFFF_FFFC;
        tick();
        chk("top.pc_F", pc_F, 32'hFFFF_FFFC);
        chk("top.align_err", {31'd0, align_err}, 32'd0);
        chk("top.cnt", {16'd0, taken_cnt}, 32'd4);
        br_op = 3'b000;
        tick();
        chk("wrap.pc_F", pc_F, 32'h0000_0000);
        chk("wrap.pc_D", pc_D, 32'hFFFF_FFFC);
        chk("wrap.pc8_D", pc8_D, 32'h0000_0004);
        chk("wrap.align_err", {31'd0, align_err}, 32'd0);

        // Saturation of the redirect counter
        br_op = 3'b011;
        for (int i = 0; i < 65530; i++) tick();
        chk("sat.cnt_fffe", {16'd0, taken_cnt}, 32'h0000_FFFE);
        tick();
        chk("sat.cnt_ffff", {16'd0, taken_cnt}, 32'h0000_FFFF);
        tick();
        tick();
        chk("sat.cnt_hold", {16'd0, taken_cnt}, 32'h0000_FFFF);

        // Asynchronous reset between edges while a jump is pending
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        chk_reset_vals("async_hold");
        reset   = 1'b1;
        br_op   = 3'b000;
        instr_F = 32'h2222_0000;
        chk("resume.pc_F", pc_F, 32'h0000_3000);
        tick();
        chk("resume1.pc_F", pc_F, 32'h0000_3004);
        chk("resume1.pc_D", pc_D, 32'h0000_3000);
        chk("resume1.instr_D", instr_D, 32'h2222_0000);
        chk("resume1.cnt", {16'd0, taken_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
